mem_axi_bridge: RTL and testbench



---
 rtl/mem_axi_pkg.sv | 20 ++
 rtl/mem_axi_bridge_if.sv | 59 +++++
 rtl/mem_axi_bridge.sv | 119 +++++++++++
 tb/tb_mem_axi_bridge.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_axi_pkg.sv
// Shared types and constants for the MEM-stage to AXI4-Lite bridge.
package mem_axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] WSTRB_WORD = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B,
        ST_DONE,
        ST_GAP
    } state_e;

endpackage

// File: rtl/mem_axi_bridge_if.sv
// MEM-side request/status signals plus the AXI4-Lite master channels of the bridge.
// Every *valid/*ready pair transfers on a rising edge where both are high; a raised
// valid and its payload stay stable until that edge, and valid never waits on ready.
interface mem_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              axi_start;
    logic              axi_rw;
    logic [ADDR_W-1:0] axi_addr;
    logic [DATA_W-1:0] axi_wdata;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [DATA_W-1:0] axi_rdata;
    logic              axi_done;
    logic              axi_err;
    logic              axi_busy;

    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;

    // Bridge view: serves MEM and masters the AXI bus.
    modport master (
        input  axi_start, axi_rw, axi_addr, axi_wdata, axi_wvalid,
        output axi_wready, axi_rdata, axi_done, axi_err, axi_busy,
        output m_araddr, m_arvalid, input m_arready,
        input  m_rdata, m_rresp, m_rvalid, output m_rready,
        output m_awaddr, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input  m_bresp, m_bvalid, output m_bready
    );

    // Environment view: MEM requester together with the AXI slave.
    modport slave (
        output axi_start, axi_rw, axi_addr, axi_wdata, axi_wvalid,
        input  axi_wready, axi_rdata, axi_done, axi_err, axi_busy,
        input  m_araddr, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready,
        input  m_awaddr, m_awvalid, output m_awready,
        input  m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready
    );

endinterface

// File: rtl/mem_axi_bridge.sv
// Turns single-beat MEM load/store requests into AXI4-Lite transactions,
// one outstanding at a time, and reports data, completion and status back to MEM.
module mem_axi_bridge
    import mem_axi_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mem_axi_bridge_if.master bus_if,
    output state_e           state_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              aw_ok_q, aw_ok_d;
    logic              w_ok_q, w_ok_d;
    logic              aw_hs, w_hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_ok_q <= 1'b0;
            w_ok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            aw_ok_q <= aw_ok_d;
            w_ok_q  <= w_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        aw_ok_d = aw_ok_q;
        w_ok_d  = w_ok_q;
        aw_hs   = 1'b0;
        w_hs    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A store request without its data is left for MEM to repeat.
                if (bus_if.axi_start && bus_if.axi_rw) begin
                    addr_d  = bus_if.axi_addr;
                    state_d = ST_AR;
                end else if (bus_if.axi_start && bus_if.axi_wvalid) begin
                    addr_d  = bus_if.axi_addr;
                    wdata_d = bus_if.axi_wdata;
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    state_d = ST_AW_W;
                end
            end
            ST_AR: begin
                if (bus_if.m_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (bus_if.m_rvalid) begin
                    rdata_d = bus_if.m_rdata;
                    err_d   = (bus_if.m_rresp != RESP_OKAY);
                    state_d = ST_DONE;
                end
            end
            ST_AW_W: begin
                // AW and W complete independently, possibly on the same edge.
                aw_hs   = !aw_ok_q && bus_if.m_awready;
                w_hs    = !w_ok_q && bus_if.m_wready;
                aw_ok_d = aw_ok_q || aw_hs;
                w_ok_d  = w_ok_q || w_hs;
                if (aw_ok_d && w_ok_d) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (bus_if.m_bvalid) begin
                    err_d   = (bus_if.m_bresp != RESP_OKAY);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_GAP;
            // MEM's registered start is still high here and must not re-trigger.
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_if.m_araddr  = addr_q;
    assign bus_if.m_arvalid = (state_q == ST_AR);
    assign bus_if.m_rready  = (state_q == ST_R);
    assign bus_if.m_awaddr  = addr_q;
    assign bus_if.m_awvalid = (state_q == ST_AW_W) && !aw_ok_q;
    assign bus_if.m_wdata   = wdata_q;
    assign bus_if.m_wstrb   = WSTRB_WORD;
    assign bus_if.m_wvalid  = (state_q == ST_AW_W) && !w_ok_q;
    assign bus_if.m_bready  = (state_q == ST_B);

    assign bus_if.axi_wready = (state_q == ST_IDLE);
    assign bus_if.axi_busy   = (state_q != ST_IDLE);
    assign bus_if.axi_rdata  = rdata_q;
    assign bus_if.axi_done   = (state_q == ST_DONE);
    assign bus_if.axi_err    = (state_q == ST_DONE) && err_q;

    assign state_o = state_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Bench for mem_axi_bridge: directed scenarios plus random traffic against a
// cycle-window model of the bridge and a configurable AXI4-Lite slave.
module tb_mem_axi_bridge;
    import mem_axi_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    state_e dbg_state;

    mem_axi_bridge_if bus ();

    mem_axi_bridge dut (
        .clk     (clk),
        .reset   (reset),
        .bus_if  (bus),
        .state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Slave configuration for the next transaction.
    int          cfg_da = 0, cfg_dw = 0, cfg_dr = 0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    // Model: one transaction described by its start cycle and phase lengths.
    int          m_e0 = -1, m_busy_until = -1, m_done_cyc = -1, m_ntxn = 0;
    int          m_da = 0, m_dw = 0, m_mx = 0, m_len = 0;
    logic        m_ld = 1'b0, m_err = 1'b0, m_pend = 1'b0, m_checking = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata_cur = '0, m_rdata_new = '0;
    logic [31:0] exp_q[$];

    // Observations.
    int          obs_done_cyc = -1;
    logic        obs_err = 1'b0;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
    logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // AXI slave: ready/valid raised after the configured number of wait cycles.
    initial begin : slave
        int ar_c, aw_c, w_c, r_c, b_c;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
        bus.m_arready = 1'b0; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
        bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rresp = 2'b00;
        bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (bus.m_arvalid) begin
                bus.m_arready = (ar_c >= cfg_da);
                if (bus.m_arready) begin
                    ar_hs++;
                    last_araddr = bus.m_araddr;
                    chk("araddr", bus.m_araddr, m_addr);
                end
                ar_c++;
            end else begin
                bus.m_arready = 1'b0;
                ar_c = 0;
            end
            if (bus.m_awvalid) begin
                bus.m_awready = (aw_c >= cfg_da);
                if (bus.m_awready) begin
                    aw_hs++;
                    last_awaddr = bus.m_awaddr;
                    chk("awaddr", bus.m_awaddr, m_addr);
                end
                aw_c++;
            end else begin
                bus.m_awready = 1'b0;
                aw_c = 0;
            end
            if (bus.m_wvalid) begin
                bus.m_wready = (w_c >= cfg_dw);
                if (bus.m_wready) begin
                    w_hs++;
                    last_wdata = bus.m_wdata;
                    last_wstrb = bus.m_wstrb;
                    chk("wdata", bus.m_wdata, m_wdata);
                    chk("wstrb", 32'(bus.m_wstrb), 32'h0000_000F);
                end
                w_c++;
            end else begin
                bus.m_wready = 1'b0;
                w_c = 0;
            end
            if (bus.m_rready) begin
                bus.m_rvalid = (r_c >= cfg_dr);
                bus.m_rdata  = bus.m_rvalid ? cfg_rdata : $urandom;
                bus.m_rresp  = bus.m_rvalid ? cfg_resp : 2'($urandom);
                if (bus.m_rvalid) r_hs++;
                r_c++;
            end else begin
                bus.m_rvalid = 1'b0;
                bus.m_rdata  = $urandom;
                r_c = 0;
            end
            if (bus.m_bready) begin
                bus.m_bvalid = (b_c >= cfg_dr);
                bus.m_bresp  = bus.m_bvalid ? cfg_resp : 2'($urandom);
                if (bus.m_bvalid) b_hs++;
                b_c++;
            end else begin
                bus.m_bvalid = 1'b0;
                b_c = 0;
            end
        end
    end

    // Model update and per-cycle compare, #1 after each rising edge.
    initial begin : compare
        int k;
        logic exp_busy, exp_done;
        logic [4:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #1;
            k = cyc;
            if (reset) begin
                m_checking   = 1'b1;
                m_busy_until = k - 1;
                m_done_cyc   = -1;
                m_rdata_cur  = '0;
                m_pend       = 1'b0;
                exp_q.delete();
            end else begin
                if (m_pend && k == m_done_cyc) begin
                    m_rdata_cur = m_rdata_new;
                    m_pend = 1'b0;
                end
                if (m_checking && (k - 1 > m_busy_until) && bus.axi_start &&
                    (bus.axi_rw || bus.axi_wvalid)) begin
                    m_e0  = k;
                    m_ld  = bus.axi_rw;
                    m_da  = cfg_da;
                    m_dw  = m_ld ? 0 : cfg_dw;
                    m_mx  = (m_da > m_dw) ? m_da : m_dw;
                    m_len = m_mx + cfg_dr;
                    m_busy_until = k + m_len + 3;
                    m_done_cyc   = k + m_len + 2;
                    m_err   = (cfg_resp != 2'b00);
                    m_addr  = bus.axi_addr;
                    m_wdata = bus.axi_wdata;
                    if (m_ld) begin
                        m_pend = 1'b1;
                        m_rdata_new = cfg_rdata;
                        exp_q.push_back(cfg_rdata);
                    end else begin
                        exp_q.push_back(m_rdata_cur);
                    end
                    m_ntxn++;
                end
            end
            if (m_checking) begin
                exp_busy = (k <= m_busy_until);
                exp_done = exp_busy && (k == m_done_cyc);
                exp_v = '0;
                if (exp_busy) begin
                    if (m_ld) begin
                        exp_v[4] = (k <= m_e0 + m_mx);
                        exp_v[3] = (k > m_e0 + m_mx) && (k <= m_e0 + m_len + 1);
                    end else begin
                        exp_v[2] = (k <= m_e0 + m_da);
                        exp_v[1] = (k <= m_e0 + m_dw);
                        exp_v[0] = (k > m_e0 + m_mx) && (k <= m_e0 + m_len + 1);
                    end
                end
                act_v = {bus.m_arvalid, bus.m_rready, bus.m_awvalid, bus.m_wvalid, bus.m_bready};
                chk("busy",   32'(bus.axi_busy),   32'(exp_busy));
                chk("wready", 32'(bus.axi_wready), 32'(!exp_busy));
                chk("done",   32'(bus.axi_done),   32'(exp_done));
                chk("err",    32'(bus.axi_err),    32'(exp_done && m_err));
                chk("rdata",  bus.axi_rdata,       m_rdata_cur);
                chk("valids", 32'(act_v),          32'(exp_v));
                if (bus.axi_done) begin
                    obs_done_cyc = k;
                    obs_err = bus.axi_err;
                    if (exp_q.size() == 0) fail("spurious_done");
                    else chk("done_rdata", bus.axi_rdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cyc > m_busy_until) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail("idle_timeout");
    endtask

    // mem_style keeps start high until the cycle after GAP, like MEM's registered strobe.
    task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic mem_style, output int k0);
        int n0;
        bit got;
        n0 = m_ntxn;
        @(negedge clk);
        bus.axi_start  = 1'b1;
        bus.axi_rw     = rw;
        bus.axi_addr   = addr;
        bus.axi_wdata  = wdata;
        bus.axi_wvalid = 1'b1;
        k0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_ntxn > n0 && (!mem_style || cyc >= m_done_cyc + 2)) begin
                got = 1'b1;
                break;
            end
        end
        bus.axi_start  = 1'b0;
        bus.axi_wvalid = 1'b0;
        bus.axi_addr   = $urandom;
        bus.axi_wdata  = $urandom;
        if (!got) fail("accept_timeout");
        wait_idle();
    endtask

    task automatic bad_store(input int n);
        @(negedge clk);
        bus.axi_start  = 1'b1;
        bus.axi_rw     = 1'b0;
        bus.axi_wvalid = 1'b0;
        bus.axi_addr   = $urandom;
        repeat (n) @(negedge clk);
        bus.axi_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_counts();
        ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
    endtask

    initial begin : main
        int k0;
        reset = 1'b1;
        bus.axi_start = 1'b0; bus.axi_rw = 1'b0; bus.axi_wvalid = 1'b0;
        bus.axi_addr = '0; bus.axi_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_wready", 32'(bus.axi_wready), 32'd1);
        chk("rst_busy",   32'(bus.axi_busy),   32'd0);
        chk("rst_done",   32'(bus.axi_done),   32'd0);
        chk("rst_rdata",  bus.axi_rdata,       32'h0);
        chk("rst_state",  32'(dbg_state),      32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait load.
        clear_counts();
        cfg_da = 0; cfg_dw = 0; cfg_dr = 0; cfg_resp = 2'b00; cfg_rdata = 32'hDEAD_BEEF;
        run_txn(1'b1, 32'h1000_0010, 32'h0, 1'b0, k0);
        chk("t1_latency", 32'(obs_done_cyc - k0), 32'd3);
        chk("t1_rdata",   bus.axi_rdata, 32'hDEAD_BEEF);
        chk("t1_araddr",  last_araddr, 32'h1000_0010);
        chk("t1_err",     32'(obs_err), 32'd0);
        chk("t1_ar_hs",   32'(ar_hs), 32'd1);

        // Store with AW ready two cycles late.
        clear_counts();
        cfg_da = 2; cfg_dw = 0; cfg_dr = 0; cfg_resp = 2'b00;
        run_txn(1'b0, 32'h0000_0040, 32'h1234_5678, 1'b0, k0);
        chk("t2_latency", 32'(obs_done_cyc - k0), 32'd5);
        chk("t2_aw_hs",   32'(aw_hs), 32'd1);
        chk("t2_w_hs",    32'(w_hs), 32'd1);
        chk("t2_wstrb",   32'(last_wstrb), 32'h0000_000F);
        chk("t2_awaddr",  last_awaddr, 32'h0000_0040);
        chk("t2_wdata",   last_wdata, 32'h1234_5678);
        chk("t2_rdata_kept", bus.axi_rdata, 32'hDEAD_BEEF);

        // Start held through done and GAP.
        clear_counts();
        cfg_da = 0; cfg_dr = 5; cfg_resp = 2'b00; cfg_rdata = 32'hCAFE_F00D;
        run_txn(1'b1, 32'h2000_0000, 32'h0, 1'b1, k0);
        repeat (3) @(negedge clk);
        chk("t3_latency", 32'(obs_done_cyc - k0), 32'd8);
        chk("t3_ar_hs",   32'(ar_hs), 32'd1);
        chk("t3_r_hs",    32'(r_hs), 32'd1);

        // Load with SLVERR.
        cfg_da = 0; cfg_dr = 0; cfg_resp = 2'b10; cfg_rdata = 32'h0BAD_F00D;
        run_txn(1'b1, 32'h3000_0004, 32'h0, 1'b0, k0);
        chk("t4_latency", 32'(obs_done_cyc - k0), 32'd3);
        chk("t4_err",     32'(obs_err), 32'd1);
        chk("t4_rdata",   bus.axi_rdata, 32'h0BAD_F00D);

        // Store start without data.
        clear_counts();
        bad_store(4);
        chk("t5_busy",  32'(bus.axi_busy), 32'd0);
        chk("t5_aw_hs", 32'(aw_hs), 32'd0);
        chk("t5_w_hs",  32'(w_hs), 32'd0);

        // Reset while waiting in B.
        clear_counts();
        cfg_da = 0; cfg_dw = 0; cfg_dr = 5; cfg_resp = 2'b00;
        @(negedge clk);
        bus.axi_start = 1'b1; bus.axi_rw = 1'b0; bus.axi_wvalid = 1'b1;
        bus.axi_addr = 32'h0000_0080; bus.axi_wdata = 32'h5555_AAAA;
        k0 = cyc;
        @(negedge clk);
        bus.axi_start = 1'b0; bus.axi_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_in_b", 32'(bus.m_bready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_bready", 32'(bus.m_bready),  32'd0);
        chk("t6_wready", 32'(bus.axi_wready), 32'd1);
        chk("t6_done",   32'(bus.axi_done),  32'd0);
        chk("t6_state",  32'(dbg_state),     32'(ST_IDLE));
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_no_done", 32'(obs_done_cyc < k0), 32'd1);
        chk("t6_b_hs",    32'(b_hs), 32'd0);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            cfg_da    = $urandom_range(0, 3);
            cfg_dw    = $urandom_range(0, 3);
            cfg_dr    = $urandom_range(0, 3);
            cfg_resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_rdata = $urandom;
            if ($urandom_range(0, 7) == 0) bad_store($urandom_range(1, 3));
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), k0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        summary();
        $finish;
    end

    initial begin : watchdog
        #300000;
        fail("watchdog");
        summary();
        $finish;
    end

endmodule
